// File: rtl/hero_motion_ctrl_if.sv
// Handshake bundle between the level renderer / input block and hero_motion_ctrl.
// The collision loop closes through coll: it is combinational on char_pos.
interface hero_motion_ctrl_if;
    logic       enable;
    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       f_key;
    logic       coll;
    logic       death;
    logic [9:0] char_pos_x;
    logic [9:0] char_pos_y;
    logic [9:0] bomb_pos_x;
    logic [9:0] bomb_pos_y;
    logic [3:0] b_cnt;
    logic [2:0] bombs_left;
    logic [1:0] lives;
    logic       game_over;

    modport master (
        output enable, key_left, key_right, key_up, f_key, coll, death,
        input  char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y,
               b_cnt, bombs_left, lives, game_over
    );

    modport slave (
        input  enable, key_left, key_right, key_up, f_key, coll, death,
        output char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y,
               b_cnt, bombs_left, lives, game_over
    );
endinterface

// File: rtl/hero_motion_ctrl.sv
// Character/bomb state machine: per-tick key and gravity moves probed one axis
// at a time against the renderer's coll flag, plus bomb fuse, lives and respawn.
module hero_motion_ctrl #(
    parameter int START_X       = 320,
    parameter int START_Y       = 440,
    parameter int STEP          = 1,
    parameter int TICK_DIV      = 416667,
    parameter int SETTLE        = 2,
    parameter int BOMB_DIV      = 60,
    parameter int BOMB_MAX      = 6,
    parameter int LIVES         = 3,
    parameter int RESPAWN_TICKS = 120
) (
    input  logic              clk,
    input  logic              reset,
    hero_motion_ctrl_if.slave io
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BOMB_DIV > 1) ? $clog2(BOMB_DIV) : 1;
    localparam int RW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BDIV_LAST = BW'(BOMB_DIV - 1);
    localparam logic [RW-1:0] RESP_LAST = RW'(RESPAWN_TICKS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE - 1);
    localparam logic [9:0]    START_X10 = 10'(START_X);
    localparam logic [9:0]    START_Y10 = 10'(START_Y);
    localparam logic [9:0]    STEP10    = 10'(STEP);
    localparam logic [10:0]   STEP11    = 11'(STEP);
    localparam logic [2:0]    BMAX3     = 3'(BOMB_MAX);
    localparam logic [1:0]    LIVES2    = 2'(LIVES);

    typedef enum logic [2:0] {IDLE, MOVE_X, CHECK_X, MOVE_Y, CHECK_Y, DEAD} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tdiv;
    logic            tick;
    logic [9:0]      x, x_n, y, y_n;
    logic [9:0]      prev, prev_n;      // one axis is probed at a time, so one rollback register
    logic [WW-1:0]   wcnt, wcnt_n;
    logic [RW-1:0]   rcnt, rcnt_n;
    logic [9:0]      bx, bx_n, by, by_n;
    logic [3:0]      bcnt, bcnt_n;
    logic [BW-1:0]   bdiv, bdiv_n;
    logic [2:0]      bleft, bleft_n;
    logic [1:0]      lives, lives_n;
    logic            gover, gover_n;
    logic            fq, fq_n;

    // Free-running move tick; keeps counting while enable is low.
    assign tick = (tdiv == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick) tdiv <= '0;
        else               tdiv <= tdiv + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            x     <= START_X10;
            y     <= START_Y10;
            prev  <= '0;
            wcnt  <= '0;
            rcnt  <= '0;
            bx    <= '0;
            by    <= '0;
            bcnt  <= '0;
            bdiv  <= '0;
            bleft <= BMAX3;
            lives <= LIVES2;
            gover <= 1'b0;
            fq    <= 1'b0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            prev  <= prev_n;
            wcnt  <= wcnt_n;
            rcnt  <= rcnt_n;
            bx    <= bx_n;
            by    <= by_n;
            bcnt  <= bcnt_n;
            bdiv  <= bdiv_n;
            bleft <= bleft_n;
            lives <= lives_n;
            gover <= gover_n;
            fq    <= fq_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        prev_n  = prev;
        wcnt_n  = wcnt;
        rcnt_n  = rcnt;
        bx_n    = bx;
        by_n    = by;
        bcnt_n  = bcnt;
        bdiv_n  = bdiv;
        bleft_n = bleft;
        lives_n = lives;
        gover_n = gover;
        fq_n    = fq;

        if (io.enable) begin
            fq_n = io.f_key;

            if (tick && bcnt != 4'd0) begin
                if (bdiv == BDIV_LAST) begin
                    bdiv_n = '0;
                    bcnt_n = (bcnt == 4'd3) ? 4'd0 : bcnt + 4'd1;
                end else begin
                    bdiv_n = bdiv + BW'(1);
                end
            end

            // Drop may land mid-probe and then captures the unrestored position.
            if (io.f_key && !fq && bcnt == 4'd0 && bleft != 3'd0 && state != DEAD) begin
                bx_n    = x;
                by_n    = y + 10'd18;
                bcnt_n  = 4'd1;
                bleft_n = bleft - 3'd1;
                bdiv_n  = '0;
            end

            if (io.death && state != DEAD) begin
                state_n = DEAD;
                rcnt_n  = '0;
                bcnt_n  = 4'd0;
                if (lives != 2'd0) lives_n = lives - 2'd1;
            end else begin
                case (state)
                    IDLE: if (tick && !gover) state_n = MOVE_X;
                    MOVE_X: begin
                        prev_n  = x;
                        wcnt_n  = '0;
                        state_n = CHECK_X;
                        if (io.key_left && !io.key_right && x >= STEP10)
                            x_n = x - STEP10;
                        else if (io.key_right && !io.key_left && ({1'b0, x} + STEP11) <= 11'd639)
                            x_n = x + STEP10;
                    end
                    CHECK_X: begin
                        if (wcnt == WAIT_LAST) begin
                            if (io.coll) x_n = prev;
                            state_n = MOVE_Y;
                        end else begin
                            wcnt_n = wcnt + WW'(1);
                        end
                    end
                    MOVE_Y: begin
                        prev_n  = y;
                        wcnt_n  = '0;
                        state_n = CHECK_Y;
                        if (io.key_up) begin
                            if (y >= STEP10) y_n = y - STEP10;
                        end else if (({1'b0, y} + STEP11) <= 11'd479) begin
                            y_n = y + STEP10;
                        end
                    end
                    CHECK_Y: begin
                        if (wcnt == WAIT_LAST) begin
                            if (io.coll) y_n = prev;
                            state_n = IDLE;
                        end else begin
                            wcnt_n = wcnt + WW'(1);
                        end
                    end
                    DEAD: begin
                        if (tick && !gover) begin
                            if (rcnt == RESP_LAST) begin
                                rcnt_n = '0;
                                if (lives != 2'd0) begin
                                    x_n     = START_X10;
                                    y_n     = START_Y10;
                                    bleft_n = BMAX3;
                                    state_n = IDLE;
                                end else begin
                                    gover_n = 1'b1;
                                end
                            end else begin
                                rcnt_n = rcnt + RW'(1);
                            end
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    assign io.char_pos_x = x;
    assign io.char_pos_y = y;
    assign io.bomb_pos_x = bx;
    assign io.bomb_pos_y = by;
    assign io.b_cnt      = bcnt;
    assign io.bombs_left = bleft;
    assign io.lives      = lives;
    assign io.game_over  = gover;
endmodule

// File: doc/hero_motion_ctrl.md
Name: hero_motion_ctrl

Overview:
- Sequential producer of the character and bomb state that every level renderer consumes: char_pos_x/y, bomb_pos_x/y, b_cnt.
- Consumes the renderer's coll and death outputs, so it closes the position -> collision loop.
- Applies player keys and gravity once per move tick, probes each axis separately, and rolls back any step that raises coll.
- Owns bomb drop/fuse sequencing, lives and respawn.

Parameters:
- START_X, 320, respawn/reset centre x (pixels)
- START_Y, 440, respawn/reset centre y (pixels)
- STEP, 1, pixels moved per axis per move tick
- TICK_DIV, 416667, clk cycles per move tick (120 Hz at 50 MHz)
- SETTLE, 2, clk cycles waited after a position change before sampling coll
- BOMB_DIV, 60, move ticks per b_cnt advance
- BOMB_MAX, 6, bombs per life
- LIVES, 3, initial lives
- RESPAWN_TICKS, 120, move ticks spent in DEAD

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  level active; low freezes all state except the tick divider
- key_left  in  1  move left, level-sensitive
- key_right  in  1  move right
- key_up  in  1  propeller; suppresses gravity and moves up
- f_key  in  1  drop bomb, rising-edge
- coll  in  1  collision flag from level renderer, combinational on char_pos
- death  in  1  death flag from level renderer
- char_pos_x  out  10  character centre x
- char_pos_y  out  10  character centre y
- bomb_pos_x  out  10  bomb centre x
- bomb_pos_y  out  10  bomb centre y
- b_cnt  out  4  bomb phase: 0 none, 1-2 fuse, 3 explosion
- bombs_left  out  3  remaining bombs
- lives  out  2  remaining lives
- game_over  out  1  sticky, no lives left

Behaviour:
- Reset values:
  - char_pos = (START_X, START_Y); bomb_pos = (0, 0)
  - b_cnt = 0, bombs_left = BOMB_MAX, lives = LIVES, game_over = 0
  - tick divider = 0, bomb divider = 0, FSM = IDLE, f_key edge register = 0
- Tick: divider counts 0..TICK_DIV-1; tick is a 1-cycle pulse at wrap. The divider runs even when enable = 0.
- FSM states and transitions:
  - IDLE: on tick with enable = 1 and game_over = 0, go to MOVE_X.
  - MOVE_X:
    - save prev_x
    - dx = -STEP if only key_left, +STEP if only key_right, else 0 (both keys pressed -> 0)
    - apply dx, go to CHECK_X
  - CHECK_X: wait SETTLE cycles, then sample coll. If coll = 1, restore prev_x. Go to MOVE_Y.
  - MOVE_Y:
    - save prev_y
    - dy = -STEP if key_up, else +STEP (gravity)
    - apply dy, go to CHECK_Y
  - CHECK_Y: wait SETTLE cycles, then sample coll. If coll = 1, restore prev_y. Go to IDLE.
  - An axis with delta 0 still passes through its CHECK state.
  - A tick arriving outside IDLE is dropped, never queued.
- Arithmetic: 10-bit unsigned; no wrap-around.
  - Left/up moves are skipped when the coordinate < STEP.
  - Right moves are skipped when x + STEP > 639; down moves when y + STEP > 479.
- Death: death = 1 in any non-DEAD state forces DEAD the next cycle.
  - Any CHECK in progress is aborted; position holds.
  - lives decrements once on entry (saturating at 0).
  - b_cnt is cleared to 0.
- DEAD: counts RESPAWN_TICKS ticks, then:
  - if lives > 0: char_pos = START, bombs_left = BOMB_MAX, go to IDLE
  - else: game_over = 1, stay in DEAD until reset
- Bomb drop: on an f_key rising edge with b_cnt = 0, bombs_left > 0, enable = 1 and not DEAD:
  - bomb_pos_x = char_pos_x, bomb_pos_y = char_pos_y + 18
  - b_cnt = 1, bombs_left decrements
  - bomb divider clears
  - The drop is accepted in any movement state; it captures the current char_pos, including an unrestored probe value.
  - Edges while b_cnt != 0 are ignored.
- Fuse: the bomb divider counts ticks while b_cnt != 0. Every BOMB_DIV ticks, b_cnt advances 1 -> 2 -> 3 -> 0. bomb_pos holds until the next drop.
- enable = 0: FSM holds its state, including mid-CHECK wait counts; bomb divider and all outputs hold.
- reset has priority over every other event, mid-move included.

Test Plan:
- Reset, free field (coll = 0), no keys, 5 ticks -> char_pos_y = 445, char_pos_x = 320.
- key_right held, coll tied high whenever char_pos_x > 330, 20 ticks -> char_pos_x settles at 330, never above for longer than SETTLE cycles.
- key_left and key_right both held, key_up held, 3 ticks -> x = 320, y = 437.
- f_key pulse at pos (320, 440) -> bomb_pos = (320, 458), b_cnt = 1, bombs_left = 5; after 60/120/180 ticks b_cnt = 2/3/0. A second f_key pulse while b_cnt = 2 is ignored.
- death pulsed 3 times, each followed by 120 ticks -> lives 2, 1, 0; position returns to (320, 440) after the first two; game_over = 1 after the third, and ticks cause no further movement.
- x = 0, key_left held, 4 ticks -> x stays 0 (no wrap to 1023); reset asserted during CHECK_Y -> all outputs at reset values the next cycle.
